// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// The fetch stage looks up PCF combinationally to get a predicted next PC.
// The execute stage trains the table when a conditional branch resolves.
// Optional statistics counters are built when BP_STATS_EN is defined.
// Without the macro, BranchCnt and MispredCnt read constant zero.
module branch_predictor #(
    parameter int ENTRY_NUM = 64,
    parameter int CNT_W     = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF,
    output logic              PredictedF,
    output logic [ADDR_W-1:0] PredictedPC,
    input  logic [ADDR_W-1:0] PCE,
    input  logic              IsBranchE,
    input  logic              BranchE,
    input  logic [ADDR_W-1:0] BrNPC,
    input  logic              PredictedE,
    input  logic              UpdateEnE,
    output logic [31:0]       BranchCnt,
    output logic [31:0]       MispredCnt
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    logic              validQ  [ENTRY_NUM];
    logic [TAG_W-1:0]  tagQ    [ENTRY_NUM];
    logic [ADDR_W-1:0] targetQ [ENTRY_NUM];
    logic [CNT_W-1:0]  cntQ    [ENTRY_NUM];

    logic [IDX_W-1:0] idxF;
    logic [IDX_W-1:0] idxE;
    logic [TAG_W-1:0] tagF;
    logic [TAG_W-1:0] tagE;
    logic             hitF;
    logic             hitE;
    logic             trainEn;

    assign idxF    = PCF[IDX_W+1:2];
    assign tagF    = PCF[ADDR_W-1:IDX_W+2];
    assign idxE    = PCE[IDX_W+1:2];
    assign tagE    = PCE[ADDR_W-1:IDX_W+2];
    assign trainEn = IsBranchE & UpdateEnE;

    // Fetch lookup reads the stored state directly, so a same-cycle train
    // to the same index is only seen from the following cycle.
    always_comb begin
        hitF        = validQ[idxF] && (tagQ[idxF] == tagF);
        hitE        = validQ[idxE] && (tagQ[idxE] == tagE);
        PredictedF  = hitF & cntQ[idxF][CNT_W-1];
        PredictedPC = PredictedF ? targetQ[idxF] : PCF + ADDR_W'(4);
    end

    // Train the entry addressed by PCE when a conditional branch leaves EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the table is built from flops rather than a RAM macro so
            // every entry can be cleared asynchronously in a single step.
            for (int i = 0; i < ENTRY_NUM; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                cntQ[i]    <= '0;
            end
        end else if (trainEn) begin
            if (hitE) begin
                if (BranchE) begin
                    if (cntQ[idxE] != CNT_MAX) begin
                        cntQ[idxE] <= cntQ[idxE] + CNT_ONE;
                    end
                    targetQ[idxE] <= BrNPC;
                end else if (cntQ[idxE] != '0) begin
                    cntQ[idxE] <= cntQ[idxE] - CNT_ONE;
                end
            end else if (BranchE) begin
                // A taken miss claims the slot; a not-taken miss leaves any
                // conflicting owner in place.
                validQ[idxE]  <= 1'b1;
                tagQ[idxE]    <= tagE;
                targetQ[idxE] <= BrNPC;
                cntQ[idxE]    <= CNT_WEAK;
            end
        end
    end

    // The low PC bits are always zero for aligned instructions and never
    // take part in indexing.
    logic unusedBits;

`ifdef BP_STATS_EN
    logic [31:0] branchCntQ;
    logic [31:0] mispredCntQ;

    // Saturating totals of resolved branches and direction mispredictions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCntQ  <= '0;
            mispredCntQ <= '0;
        end else if (trainEn) begin
            if (branchCntQ != 32'hFFFF_FFFF) begin
                branchCntQ <= branchCntQ + 32'd1;
            end
            if ((PredictedE != BranchE) && (mispredCntQ != 32'hFFFF_FFFF)) begin
                mispredCntQ <= mispredCntQ + 32'd1;
            end
        end
    end

    assign BranchCnt  = branchCntQ;
    assign MispredCnt = mispredCntQ;
    assign unusedBits = ^{PCF[1:0], PCE[1:0]};
`else
    assign BranchCnt  = '0;
    assign MispredCnt = '0;
    assign unusedBits = ^{PCF[1:0], PCE[1:0], PredictedE};
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters, replacing the fetch-stage 1-bit BTB of the RV32 pipeline. The IF stage looks up the current fetch PC combinationally to get a predicted next PC. The EX stage trains the table when a conditional branch resolves. Optional statistics counters report resolved-branch and misprediction totals for on-board performance measurement.

## Interface
- ENTRY_NUM, 64, number of table entries; power of two, 2..1024; IDX_W = clog2(ENTRY_NUM)
- CNT_W, 2, direction-counter width, 1..4; predict taken when counter MSB = 1
- ADDR_W, 32, PC width
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- PCF  input  ADDR_W  fetch-stage PC for lookup
- PredictedF  output  1  lookup hit and counter MSB = 1
- PredictedPC  output  ADDR_W  stored target when PredictedF = 1, else PCF + 4
- PCE  input  ADDR_W  PC of the instruction in EX
- IsBranchE  input  1  the instruction in EX is a conditional branch
- BranchE  input  1  the branch resolved taken
- BrNPC  input  ADDR_W  resolved branch target
- PredictedE  input  1  PredictedF value carried down the pipeline with that branch
- UpdateEnE  input  1  EX stage advancing (~StallE & ~FlushE); gates training and statistics
- BranchCnt  output  32  resolved conditional branches (statistics)
- MispredCnt  output  32  direction mispredictions (statistics)

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target[ADDR_W], and cnt[CNT_W].
- **Lookup** is combinational from PCF.
  - hit = valid[idx] & (tag[idx] == tagF).
  - PredictedF = hit & cnt[idx][CNT_W-1].
- **Train** happens at the clock edge when IsBranchE & UpdateEnE:
  - Hit at PCE, taken: cnt saturating +1 (max 2^CNT_W-1); target <= BrNPC.
  - Hit at PCE, not taken: cnt saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate or overwrite the entry. Set valid = 1, tag = tagE, target = BrNPC, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change. A conflicting entry at the same index is preserved.
- No training when IsBranchE = 0 (including jal/jalr) or UpdateEnE = 0.
- A mispredict is PredictedE != BranchE. Target mismatch cannot occur, because full tags mean only one PC maps to an entry and branch targets are static.
- CNT_W = 1 degenerates to a last-outcome predictor: a hit on a not-taken branch clears the entry's cnt, and the entry stays valid.

## Timing
- Lookup has zero latency: PredictedF/PredictedPC settle in the same cycle as PCF.
- Training takes effect on the next rising edge and is visible to lookups from the following cycle.
- Simultaneous lookup and train to the same index: the lookup returns the pre-update contents (read-before-write). The new contents are seen one cycle later.
- Reset (asserted low, any time, asynchronous):
  - All valid, cnt, and target bits clear.
  - PredictedF = 0; PredictedPC = PCF + 4 immediately.
  - BranchCnt = MispredCnt = 0.
  - A train edge coincident with reset assertion is dropped.
- Reset release takes effect at the first rising edge after rst goes high. Training resumes from that edge.
- PCF + 4 wraps modulo 2^ADDR_W.

## Configuration
- BP_STATS_EN defined: two 32-bit counters.
  - BranchCnt increments on each IsBranchE & UpdateEnE edge.
  - MispredCnt increments on the same condition when PredictedE != BranchE.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by reset.
- BP_STATS_EN undefined: the counters are not built. BranchCnt and MispredCnt are driven to constant 0 and the ports remain present. Prediction behaviour is identical either way.

## Test plan
- After reset with PCF = 0x0000_0100: PredictedF = 0 and PredictedPC = 0x0000_0104. Repeat with PCF = 0xFFFF_FFFC: PredictedPC = 0x0000_0000.
- Cold allocate:
  - Train PCE = 0x100, BranchE = 1, BrNPC = 0x80, IsBranchE = 1, UpdateEnE = 1.
  - Next cycle, PCF = 0x100 gives PredictedF = 1 and PredictedPC = 0x80; cnt = 2'b10.
- Hysteresis (CNT_W = 2) on the allocated 0x100 entry:
  - One not-taken train gives cnt = 01 and PredictedF = 0.
  - Two taken trains give cnt = 11, then one not-taken gives cnt = 10 and PredictedF = 1.
  - Further taken trains hold cnt at 11.
- Aliasing (ENTRY_NUM = 64, index = PC[7:2], so 0x100 and 0x200 share index 0): with 0x100 allocated, a not-taken miss train at PCE = 0x200 leaves 0x100 predicted. A taken train at 0x200 with BrNPC = 0x300 evicts it, so lookup 0x100 gives PredictedF = 0 and lookup 0x200 gives PredictedPC = 0x300.
- Gating and collision:
  - A train with UpdateEnE = 0 or IsBranchE = 0 changes nothing.
  - In the cycle PCF = PCE = 0x100 with an allocating train, lookup gives PredictedF = 0; the next cycle gives PredictedF = 1.
- Statistics (BP_STATS_EN): 5 trains with PredictedE/BranchE pairs 0/1, 1/1, 1/0, 0/0, 1/1 give BranchCnt = 5 and MispredCnt = 2. Asserting rst mid-sequence zeroes both immediately. Without the macro, both outputs read 0 throughout.
